// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file slice.
// Default widths, the zero-register address and the INIT/RUN state encoding.
package mips_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    // An address names a writable register only when it is not $zero.
    function automatic logic is_gpr(input logic [4:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/mips_regfile_init_seq.sv
// Post-reset sweep sequencer for the register file.
// Steps sweep_idx through every entry once, then raises ready.
module regfile_init_seq
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // The index parks at all-ones; it never wraps back into the file.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            INIT: begin
                if (idx == LAST_IDX) begin
                    state_nxt = RUN;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        sweep_en  = 1'b0;
        sweep_idx = idx;
        unique case (state)
            INIT: sweep_en = 1'b1;
            RUN:  ready    = 1'b1;
            default: begin
                ready    = 1'b0;
                sweep_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32 MIPS general-purpose register file, two read ports, one write port.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              ready
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_idx;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ext_wr;

    regfile_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .sweep_en  (sweep_en),
        .sweep_idx (sweep_idx)
    );

    assign ext_wr = reg_write && (write_reg != ZERO_ADDR);

    // The sweep owns the write port until RUN; external writes are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sweep_idx;
        wr_data = '0;
        if (sweep_en) begin
            wr_en = 1'b1;
        end else if (ext_wr) begin
            wr_en   = 1'b1;
            wr_addr = write_reg;
            wr_data = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        if (ready && (read_reg1 != ZERO_ADDR)) begin
            read_data1 = regs[read_reg1];
`ifdef REGFILE_BYPASS_EN
            if (ext_wr && (write_reg == read_reg1)) begin
                read_data1 = write_data;
            end
`endif
        end
    end

    always_comb begin
        read_data2 = '0;
        if (ready && (read_reg2 != ZERO_ADDR)) begin
            read_data2 = regs[read_reg2];
`ifdef REGFILE_BYPASS_EN
            if (ext_wr && (write_reg == read_reg2)) begin
                read_data2 = write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed plan plus random traffic
// compared against an array-based reference model.
module tb_mips_regfile;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [NREG];
    int          init_left = NREG;

    always #5 clk = ~clk;

    mips_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .ready      (ready)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (init_left > 0 || ra == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_reg == ra) return write_data;
`endif
        return mem[ra];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Register contents become all-zero the moment the sweep completes.
    task automatic model_edge();
        if (reset) begin
            init_left = NREG;
        end else if (init_left > 0) begin
            init_left--;
            if (init_left == 0) begin
                for (int i = 0; i < NREG; i++) mem[i] = 32'd0;
            end
        end else if (reg_write && write_reg != 5'd0) begin
            mem[write_reg] = write_data;
        end
    endtask

    task automatic cycle();
        #1;
        chk("ready", {31'd0, ready}, {31'd0, init_left == 0});
        chk("rd1", read_data1, exp_rd(read_reg1));
        chk("rd2", read_data2, exp_rd(read_reg2));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        cycle();
        idle();
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        idle();
        for (int i = 0; i < NREG; i++) mem[i] = 32'd0;

        // First edge unchecked: DUT state is undefined before it.
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cycle();
        cycle();

        // Reset release, hammer reg 5 with writes throughout INIT.
        reset      = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'hDEADBEEF;
        read_reg1  = 5'd5;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            cnt++;
            if (ready === 1'b1) break;
        end
        chk("ready_latency", 32'(cnt), 32'd32);
        cycle();
        #1;
        chk("reg5_first_run", read_data1, 32'hDEADBEEF);
        idle();

        // Zero register.
        wr(5'd0, 32'hFFFFFFFF);
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        #1;
        chk("zero_rd1", read_data1, 32'd0);
        chk("zero_rd2", read_data2, 32'd0);
        cycle();

        // Dual read, then swapped.
        wr(5'd8, 32'h12345678);
        wr(5'd31, 32'hA5A5A5A5);
        read_reg1 = 5'd8;
        read_reg2 = 5'd31;
        #1;
        chk("dual_rd1", read_data1, 32'h12345678);
        chk("dual_rd2", read_data2, 32'hA5A5A5A5);
        read_reg1 = 5'd31;
        read_reg2 = 5'd8;
        #1;
        chk("swap_rd1", read_data1, 32'hA5A5A5A5);
        chk("swap_rd2", read_data2, 32'h12345678);
        cycle();

        // Same-cycle read/write of reg 9.
        wr(5'd9, 32'h1);
        read_reg1  = 5'd9;
        read_reg2  = 5'd9;
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rw_same_cycle", read_data1, 32'h2);
`else
        chk("rw_same_cycle", read_data1, 32'h1);
`endif
        cycle();
        idle();
        #1;
        chk("rw_next_cycle", read_data2, 32'h2);

        // Mid-operation reset with a coincident write.
        wr(5'd3, 32'h77);
        read_reg1  = 5'd3;
        reset      = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'h55;
        cycle();
        reset = 1'b0;
        idle();
        #1;
        chk("mid_reset_ready", {31'd0, ready}, 32'd0);
        for (int i = 0; i < NREG; i++) cycle();
        #1;
        chk("mid_reset_ready_back", {31'd0, ready}, 32'd1);
        chk("mid_reset_reg3", read_data1, 32'd0);

        // Write on the final sweep cycle is dropped.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < NREG - 1; i++) cycle();
        wr(5'd4, 32'hCAFE);
        read_reg1 = 5'd4;
        #1;
        chk("final_init_ready", {31'd0, ready}, 32'd1);
        chk("final_init_reg4", read_data1, 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            reg_write  = $urandom_range(0, 1) == 1;
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg
                                                     : 5'($urandom_range(0, 31));
            read_reg2  = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
